// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing helper for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Minimum number of BCD digits that can hold 2^bin_w - 1 without overflow.
    function automatic int digits_for(input int bin_w);
        longint max_val;
        longint lim;
        int     d;
        max_val = (64'sd1 <<< bin_w) - 64'sd1;
        lim     = 64'sd10;
        d       = 1;
        for (int i = 0; i < 20; i++) begin
            if (max_val >= lim) begin
                d   = d + 1;
                lim = lim * 64'sd10;
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: add 3 when the digit is 5 or more (4-bit wrap).
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // add-3 correction so the following doubling carries correctly into the next digit
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking output enabled by BIN2BCD_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 11,
    parameter int DIGITS = 4
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int              CNT_W    = $clog2(BIN_W);
    localparam int              WORK_W   = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t              state_r, state_nx;
    logic [BIN_W-1:0]    shift_r, shift_nx;
    logic [WORK_W-1:0]   work_r, work_nx;
    logic                sticky_r, sticky_nx;
    logic [CNT_W-1:0]    cnt_r, cnt_nx;
    logic [WORK_W-1:0]   bcd_r, bcd_nx;
    logic                ovf_r, ovf_nx;
    logic                valid_r, valid_nx;

    logic [WORK_W-1:0]   adj_s;
    logic [WORK_W-1:0]   work_shift_s;
    logic                carry_s;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (work_r[4*g +: 4]),
                .dout (adj_s[4*g +: 4])
            );
        end
    endgenerate

    // The top digit's MSB falls off the work register; it marks value >= 10^DIGITS.
    assign carry_s      = adj_s[WORK_W-1];
    assign work_shift_s = {adj_s[WORK_W-2:0], shift_r[BIN_W-1]};

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]   blank_r, blank_nx;
    logic [DIGITS-1:0]   blank_s;
    logic                zero_above_s;

    // blank[d] set when digit d and every digit above it are zero; digit 0 always shown
    always_comb begin
        blank_s      = {DIGITS{1'b0}};
        zero_above_s = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zero_above_s = zero_above_s & (work_shift_s[4*d +: 4] == 4'd0);
            blank_s[d]   = zero_above_s;
        end
    end
`endif

    // next-state and datapath update for IDLE/CONV
    always_comb begin
        state_nx  = state_r;
        shift_nx  = shift_r;
        work_nx   = work_r;
        sticky_nx = sticky_r;
        cnt_nx    = cnt_r;
        bcd_nx    = bcd_r;
        ovf_nx    = ovf_r;
        valid_nx  = 1'b0;
`ifdef BIN2BCD_BLANK_EN
        blank_nx  = blank_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx  = CONV;
                    shift_nx  = bin;
                    work_nx   = {WORK_W{1'b0}};
                    sticky_nx = 1'b0;
                    cnt_nx    = {CNT_W{1'b0}};
                end else begin
                    state_nx  = IDLE;
                end
            end
            CONV: begin
                shift_nx  = {shift_r[BIN_W-2:0], 1'b0};
                work_nx   = work_shift_s;
                sticky_nx = sticky_r | carry_s;
                if (cnt_r == CNT_LAST) begin
                    state_nx = IDLE;
                    bcd_nx   = work_shift_s;
                    ovf_nx   = sticky_r | carry_s;
                    valid_nx = 1'b1;
`ifdef BIN2BCD_BLANK_EN
                    blank_nx = blank_s;
`endif
                end else begin
                    cnt_nx   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // state and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            shift_r  <= {BIN_W{1'b0}};
            work_r   <= {WORK_W{1'b0}};
            sticky_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            bcd_r    <= {WORK_W{1'b0}};
            ovf_r    <= 1'b0;
            valid_r  <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank_r  <= {DIGITS{1'b0}};
`endif
        end else begin
            state_r  <= state_nx;
            shift_r  <= shift_nx;
            work_r   <= work_nx;
            sticky_r <= sticky_nx;
            cnt_r    <= cnt_nx;
            bcd_r    <= bcd_nx;
            ovf_r    <= ovf_nx;
            valid_r  <= valid_nx;
`ifdef BIN2BCD_BLANK_EN
            blank_r  <= blank_nx;
`endif
        end
    end

    assign ready = (state_r == IDLE);
    assign busy  = (state_r == CONV);
    assign valid = valid_r;
    assign bcd   = bcd_r;
    assign ovf   = ovf_r;
`ifdef BIN2BCD_BLANK_EN
    assign blank = blank_r;
`endif

endmodule
